peripheral_arbiter_write_axi4: RTL and testbench

PERIPHERAL_ARBITER_WRITE_AXI4 -- requirements
Module: peripheral_arbiter_write_axi4

---
 rtl/peripheral_arbiter_axi4_pkg.sv | 34 +++
 rtl/peripheral_arbiter_rr.sv | 28 ++
 rtl/peripheral_arbiter_write_axi4.sv | 140 ++++++++++++++
 tb/tb_peripheral_arbiter_write_axi4.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_arbiter_axi4_pkg.sv
// Shared widths, field positions and FSM states for the AXI4 write arbiter.
package peripheral_arbiter_axi4_pkg;

  // AW attributes below the address: awlen(4) awsize(3) awburst(2) awlock(1) awcache(4) awprot(3)
  localparam int AW_ATTR_W = 17;
  localparam int AWLEN_LSB = 13;

  function automatic int aw_width(input int id_w, input int addr_w);
    return id_w + addr_w + AW_ATTR_W;
  endfunction

  // {wid, wrdata, wstrb, wlast}
  function automatic int w_width(input int id_w, input int data_w);
    return id_w + data_w + data_w / 8 + 1;
  endfunction

  // {bid, bresp}
  function automatic int b_width(input int id_w);
    return id_w + 2;
  endfunction

  // Widths for the default configuration (ID 4, ADDR 32, DATA 32)
  localparam int AW_W = aw_width(4, 32);
  localparam int W_W  = w_width(4, 32);
  localparam int B_W  = b_width(4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } arb_state_e;

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Round-robin pick: first requester at or after ptr, wrapping; one-hot out.
module peripheral_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan from the pointer upward; the first hit wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = PTR_W'((int'(ptr) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_write_axi4.sv
// N:1 AXI4 write arbiter, one transaction outstanding, round-robin fairness.
module peripheral_arbiter_write_axi4
  import peripheral_arbiter_axi4_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ID_WIDTH    = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  localparam int AW_BITS    = aw_width(ID_WIDTH, ADDR_WIDTH),
  localparam int W_BITS     = w_width(ID_WIDTH, DATA_WIDTH),
  localparam int B_BITS     = b_width(ID_WIDTH)
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [NUM_MASTERS-1:0]         m_awvalid,
  output logic [NUM_MASTERS-1:0]         m_awready,
  input  logic [NUM_MASTERS*AW_BITS-1:0] m_aw,
  input  logic [NUM_MASTERS-1:0]         m_wvalid,
  output logic [NUM_MASTERS-1:0]         m_wready,
  input  logic [NUM_MASTERS*W_BITS-1:0]  m_w,
  output logic [NUM_MASTERS-1:0]         m_bvalid,
  input  logic [NUM_MASTERS-1:0]         m_bready,
  output logic [B_BITS-1:0]              m_b,
  output logic                           s_awvalid,
  input  logic                           s_awready,
  output logic [AW_BITS-1:0]             s_aw,
  output logic                           s_wvalid,
  input  logic                           s_wready,
  output logic [W_BITS-1:0]              s_w,
  input  logic                           s_bvalid,
  output logic                           s_bready,
  input  logic [B_BITS-1:0]              s_b
);

  localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state, state_nxt;
  logic [PTR_W-1:0]       grant, ptr, rr_idx;
  logic [NUM_MASTERS-1:0] rr_grant;
  logic [3:0]             beat, awlen_q;
  logic [AW_BITS-1:0]     aw_sel;
  logic [W_BITS-1:0]      w_sel;
  logic                   last_beat;

  peripheral_arbiter_rr #(
    .NUM_MASTERS (NUM_MASTERS),
    .PTR_W       (PTR_W)
  ) u_rr (
    .req   (m_awvalid),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  // One-hot winner to index
  always_comb begin
    rr_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (rr_grant[k]) rr_idx = PTR_W'(k);
  end

  // Route the granted master's AW/W payload
  always_comb begin
    aw_sel = '0;
    w_sel  = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (grant == PTR_W'(k)) begin
        aw_sel = m_aw[k*AW_BITS +: AW_BITS];
        w_sel  = m_w[k*W_BITS +: W_BITS];
      end
  end

  // wlast is generated from the latched burst length; the master's own flag is ignored
  assign last_beat = (beat == awlen_q);

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Grant, fairness pointer, burst length and beat counter
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant   <= '0;
      ptr     <= '0;
      beat    <= '0;
      awlen_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|m_awvalid) grant <= rr_idx;
        ST_ADDR: if (s_awready) begin
          awlen_q <= aw_sel[AWLEN_LSB +: 4];
          beat    <= '0;
        end
        ST_DATA: if (m_wvalid[grant] && s_wready) beat <= beat + 4'd1;
        ST_RESP: if (s_bvalid && m_bready[grant])
          ptr <= (grant == PTR_W'(NUM_MASTERS - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

  // Next state and channel steering; only the granted master sees ready/bvalid
  always_comb begin
    state_nxt = state;
    s_awvalid = 1'b0;
    s_aw      = '0;
    s_wvalid  = 1'b0;
    s_w       = '0;
    s_bready  = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    m_b       = '0;
    case (state)
      ST_IDLE: if (|m_awvalid) state_nxt = ST_ADDR;
      ST_ADDR: begin
        s_awvalid        = 1'b1;
        s_aw             = aw_sel;
        m_awready[grant] = s_awready;
        if (s_awready) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        s_wvalid        = m_wvalid[grant];
        s_w             = w_sel;
        s_w[0]          = last_beat;
        m_wready[grant] = s_wready;
        if (m_wvalid[grant] && s_wready && last_beat) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        s_bready        = m_bready[grant];
        m_bvalid[grant] = s_bvalid;
        m_b             = s_b;
        if (s_bvalid && m_bready[grant]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_peripheral_arbiter_write_axi4.sv
// Scoreboard bench: masters push expected AW/W, slave pushes expected B,
// a negedge monitor predicts the grant and checks every handshake.
module tb_peripheral_arbiter_write_axi4;
  import peripheral_arbiter_axi4_pkg::*;

  localparam int N   = 2;
  localparam int IDW = 4;
  localparam int AWB = aw_width(IDW, 32);
  localparam int WB  = w_width(IDW, 32);
  localparam int BB  = b_width(IDW);
  localparam int PW  = 1;

  typedef struct { int m; logic [AWB-1:0] aw; } aw_item_t;
  typedef struct { int m; logic [WB-1:0]  w;  } w_item_t;

  logic aclk = 1'b0;
  logic aresetn;
  logic [N-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [N*AWB-1:0] m_aw;
  logic [N*WB-1:0]  m_w;
  logic [BB-1:0]    m_b;
  logic             s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [AWB-1:0]   s_aw;
  logic [WB-1:0]    s_w;
  logic [BB-1:0]    s_b;

  int checks = 0, failures = 0, done_cnt = 0;
  logic [N-1:0] en, mbusy;
  bit abort, eager, zw, zw_chk, mon_active;
  int fixed_len, mon_beat;

  aw_item_t       exp_aw[$];
  w_item_t        exp_w[$];
  logic [BB-1:0]  exp_b[$];

  always #5 aclk = ~aclk;

  peripheral_arbiter_write_axi4 #(
    .NUM_MASTERS(N), .ID_WIDTH(IDW), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string nm);
    chk(nm, 64'({s_awvalid, s_wvalid, s_bready, m_awready, m_wready, m_bvalid}), 64'd0);
  endtask

  // Masters: each issues one whole write at a time (AW, then awlen+1 beats, then B)
  for (genvar g = 0; g < N; g++) begin : gm
    logic awv, wv, bry, busy;
    logic [AWB-1:0] aw;
    logic [WB-1:0]  w;
    assign m_awvalid[g]        = awv;
    assign m_wvalid[g]         = wv;
    assign m_bready[g]         = bry;
    assign m_aw[g*AWB +: AWB]  = aw;
    assign m_w[g*WB +: WB]     = w;
    assign mbusy[g]            = busy;

    initial begin
      int len;
      bit hs;
      aw_item_t ai;
      w_item_t  wi;
      awv = 0; wv = 0; bry = 0; busy = 0; aw = '0; w = '0;
      forever begin
        @(posedge aclk); #1;
        if (en[g] && aresetn && !abort) begin
          busy = 1;
          len  = (fixed_len >= 0) ? fixed_len : int'($urandom_range(0, 7));
          aw   = AWB'({$urandom, $urandom});
          aw[AWLEN_LSB +: 4] = 4'(len);
          ai.m = g; ai.aw = aw;
          exp_aw.push_back(ai);
          awv = 1; hs = 0;
          while (!hs && !abort) begin
            @(negedge aclk); hs = m_awready[g];
            @(posedge aclk); #1;
          end
          awv = 0;
          for (int b = 0; b <= len && !abort; b++) begin
            w = WB'({$urandom, $urandom});
            wi.m = g; wi.w = w;
            exp_w.push_back(wi);
            hs = 0;
            while (!hs && !abort) begin
              wv = eager || ($urandom_range(0, 3) != 0);
              @(negedge aclk); hs = wv && m_wready[g];
              @(posedge aclk); #1;
            end
            wv = 0;
          end
          hs = 0;
          while (!hs && !abort) begin
            bry = eager || ($urandom_range(0, 2) != 0);
            @(negedge aclk); hs = bry && m_bvalid[g];
            @(posedge aclk); #1;
          end
          bry = 0; busy = 0;
        end
      end
    end
  end

  // Slave: random ready stalls (with occasional 5-cycle W stalls), delayed B echoing awid
  initial begin : slave
    bit wl, bh;
    int bdly, stall;
    logic [IDW-1:0] last_id;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_b = '0;
    bdly = -1; stall = 0; last_id = '0;
    forever begin
      @(negedge aclk);
      wl = s_wvalid && s_wready && s_w[0];
      bh = s_bvalid && s_bready;
      if (s_awvalid && s_awready) last_id = s_aw[AWB-1 -: IDW];
      @(posedge aclk); #1;
      if (!aresetn) begin
        s_awready = 0; s_wready = 0; s_bvalid = 0; bdly = -1; stall = 0;
      end else begin
        s_awready = zw || ($urandom_range(0, 2) != 0);
        if (stall > 0) begin
          stall--; s_wready = 0;
        end else if (!zw && $urandom_range(0, 19) == 0) begin
          stall = 4; s_wready = 0;
        end else
          s_wready = zw || ($urandom_range(0, 3) != 0);
        if (bh) s_bvalid = 0;
        if (wl) bdly = zw ? 0 : int'($urandom_range(0, 12));
        if (bdly == 0) begin
          s_bvalid = 1;
          s_b = {last_id, 2'($urandom_range(0, 3))};
          exp_b.push_back(s_b);
          bdly = -1;
        end else if (bdly > 0) bdly--;
      end
    end
  end

  // Monitor: predicts round-robin winner from the requests seen in the deciding cycle
  initial begin : mon
    logic [N-1:0]   prev_req;
    logic           prev_sawv;
    logic [PW-1:0]  cur_m;
    logic [AWB-1:0] cur_aw;
    logic [WB-1:0]  ew;
    int exp_m, idx, model_ptr, ph, len, cyc;
    w_item_t wi;
    prev_req = '0; prev_sawv = 0; cur_m = '0; cur_aw = '0;
    model_ptr = 0; ph = 0; len = 0; cyc = 0; mon_active = 0; mon_beat = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_req = '0; prev_sawv = 0; model_ptr = 0; ph = 0;
        mon_active = 0; mon_beat = 0;
        exp_aw.delete(); exp_w.delete(); exp_b.delete();
        continue;
      end
      if (s_awvalid && !prev_sawv) begin
        exp_m = -1;
        for (int k = 0; k < N; k++) begin
          idx = (model_ptr + k) % N;
          if (exp_m < 0 && prev_req[idx]) exp_m = idx;
        end
        idx = -1;
        foreach (exp_aw[k]) if (idx < 0 && exp_aw[k].m == exp_m) idx = k;
        checks++;
        if (exp_m < 0 || idx < 0) begin
          failures++;
          $display("FAIL grant: got s_aw %0h with no eligible requester (ptr %0d req %b)", s_aw, model_ptr, prev_req);
          exp_m = 0; cur_aw = '0;
        end else begin
          cur_aw = exp_aw[idx].aw;
          exp_aw.delete(idx);
          if (s_aw !== cur_aw) begin
            failures++;
            $display("FAIL grant: got s_aw %0h expected master %0d aw %0h", s_aw, exp_m, cur_aw);
          end
        end
        cur_m = PW'(exp_m); mon_active = 1; ph = 1; cyc = 0; mon_beat = 0;
      end
      if (mon_active) cyc++;
      for (int i = 0; i < N; i++)
        if (!(mon_active && PW'(i) == cur_m))
          chk("ungranted_quiet", 64'({m_awready[i], m_wready[i], m_bvalid[i]}), 64'd0);
      if (!mon_active)
        chk("idle_outs", 64'({s_awvalid, s_wvalid, s_bready, m_b}), 64'd0);
      if (ph == 1) begin
        chk("aw_ready_pass", 64'(m_awready[cur_m]), 64'(s_awready));
        if (s_awvalid && s_awready) begin
          chk("aw_payload", 64'(s_aw), 64'(cur_aw));
          len = int'(cur_aw[AWLEN_LSB +: 4]); ph = 2;
        end
      end else if (ph == 2) begin
        chk("w_pass", 64'({s_wvalid, m_wready[cur_m]}), 64'({m_wvalid[cur_m], s_wready}));
        if (s_wvalid && s_wready) begin
          if (exp_w.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_beat: got %0h expected nothing (queue empty)", s_w);
          end else begin
            wi = exp_w.pop_front();
            ew = wi.w;
            ew[0] = (mon_beat == len);
            chk("w_beat", 64'({2'(wi.m), s_w}), 64'({2'(cur_m), ew}));
          end
          mon_beat++;
          if (mon_beat == len + 1) ph = 3;
        end
      end else if (ph == 3 && s_bvalid) begin
        chk("b_pass", 64'({m_bvalid[cur_m], s_bready}), 64'({1'b1, m_bready[cur_m]}));
        if (s_bready) begin
          if (exp_b.size() == 0) begin
            checks++; failures++;
            $display("FAIL b_resp: got %0h expected nothing (queue empty)", m_b);
          end else
            chk("b_resp", 64'(m_b), 64'(exp_b.pop_front()));
          if (zw_chk) chk("txn_cycles", 64'(cyc + 1), 64'(len + 4));
          model_ptr = (int'(cur_m) + 1) % N;
          mon_active = 0; ph = 0; done_cnt++;
        end
      end
      prev_sawv = s_awvalid;
      prev_req  = m_awvalid;
    end
  end

  task automatic run(input int n, input string nm);
    int base, t;
    base = done_cnt; t = 0;
    while (done_cnt < base + n && t < 20000) begin @(negedge aclk); t++; end
    chk({nm, "_done"}, 64'(done_cnt >= base + n), 64'd1);
    en = '0; t = 0;
    while (mbusy != '0 && t < 2000) begin @(negedge aclk); t++; end
    chk({nm, "_drain"}, 64'(mbusy), 64'd0);
    repeat (2) @(negedge aclk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t;
    en = '0; abort = 0; eager = 0; zw = 1; zw_chk = 0; fixed_len = -1; aresetn = 0;
    repeat (3) @(negedge aclk);
    chk_outs("reset_outs");
    #2 aresetn = 1;
    repeat (3) @(negedge aclk);
    chk_outs("idle_no_req");

    // master 0 alone, awlen=3, zero-wait slave: 7 cycles per transaction
    eager = 1; zw = 1; fixed_len = 3; zw_chk = 1; en = 2'b01;
    run(3, "single_m0");
    zw_chk = 0;

    // both masters saturating: strict alternation
    fixed_len = -1; en = 2'b11;
    run(12, "rr_eager");

    // random bubbles, stalls and B delays
    eager = 0; zw = 0; en = 2'b11;
    run(60, "random");

    // single-beat bursts from master 1 with slow B
    fixed_len = 0; en = 2'b10;
    run(4, "m1_len0");

    // reset in the middle of a burst
    eager = 1; zw = 1; fixed_len = 3; en = 2'b11; t = 0;
    while (!(mon_active && mon_beat == 2) && t < 2000) begin @(negedge aclk); t++; end
    chk("mid_burst_reached", 64'(mon_beat), 64'd2);
    #1 aresetn = 0; abort = 1;
    #1 chk_outs("reset_mid_burst");
    repeat (4) @(negedge aclk);
    chk_outs("reset_hold");
    abort = 0;
    @(negedge aclk); #2 aresetn = 1;
    t = 0;
    while (!s_awvalid && t < 100) begin @(negedge aclk); t++; end
    chk("post_reset_grant", 64'(m_awready), 64'(2'b01));
    run(4, "post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
